// File: rtl/crc10_frame_gen.sv
// rtl/crc10_frame_gen.sv - 26-beat framer appending four CRC-10 lane checksums on the tail beat
// Beats pass through unchanged; beat 25 carries the lane CRCs in place of its unused low bits.
module crc10_frame_gen #(
    parameter logic [9:0] POLY = 10'b1000110011,
    parameter logic [3:0] TAIL = 4'b0
) (
    input  logic        clk_390p625M,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [61:0] in_data,
    input  logic        err_inject,
    output logic        crc10_en,
    output logic [61:0] crc10_data_out,
    output logic        frame_tail_flag,
    output logic [15:0] frame_cnt,
    output logic        sync_err
);

    localparam logic [4:0] LAST_BEAT = 5'd25;

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    state_t      state;
    logic [4:0]  beat_cnt;
    logic [9:0]  lane1, lane2, lane3, lane4;
    logic        inject_pending;

    logic [9:0]  base1, base2, base3, base4;
    logic [9:0]  full1, full2, full3, full4;
    logic [9:0]  part2;
    logic [9:0]  c1_out;
    logic [61:0] tail_word;

    // MSB-first serial CRC over the low nbits of bits, highest of those bits first.
    function automatic logic [9:0] crc_upd(input logic [9:0] crc, input logic [15:0] bits,
                                           input int nbits);
        logic [9:0] c;
        logic       fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[9] ^ bits[i];
                c  = {c[8:0], 1'b0} ^ (fb ? POLY : 10'h000);
            end
        end
        return c;
    endfunction

    always_comb begin
        base1 = in_sof ? 10'h000 : lane1;
        base2 = in_sof ? 10'h000 : lane2;
        base3 = in_sof ? 10'h000 : lane3;
        base4 = in_sof ? 10'h000 : lane4;
        full1 = crc_upd(base1, {1'b0, in_data[61:47]}, 15);
        full2 = crc_upd(base2, in_data[46:31], 16);
        full3 = crc_upd(base3, {1'b0, in_data[30:16]}, 15);
        full4 = crc_upd(base4, in_data[15:0], 16);
        part2 = crc_upd(lane2, {13'h0000, in_data[46:44]}, 3);
        c1_out = full1 ^ {9'h000, inject_pending};
        // Tail layout: 18 live payload bits, then C1..C4 and the fixed TAIL nibble.
        tail_word = {in_data[61:44], c1_out, part2, lane3, lane4, TAIL};
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            beat_cnt        <= 5'd0;
            lane1           <= 10'h000;
            lane2           <= 10'h000;
            lane3           <= 10'h000;
            lane4           <= 10'h000;
            inject_pending  <= 1'b0;
            crc10_en        <= 1'b0;
            crc10_data_out  <= 62'h0;
            frame_tail_flag <= 1'b0;
            frame_cnt       <= 16'h0000;
            sync_err        <= 1'b0;
        end else begin
            crc10_en        <= 1'b0;
            frame_tail_flag <= 1'b0;
            sync_err        <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // A start while in BODY aborts the open frame silently apart from sync_err.
                    sync_err       <= (state == BODY);
                    lane1          <= full1;
                    lane2          <= full2;
                    lane3          <= full3;
                    lane4          <= full4;
                    inject_pending <= err_inject;
                    beat_cnt       <= 5'd1;
                    state          <= BODY;
                    crc10_en       <= 1'b1;
                    crc10_data_out <= in_data;
                end else if (state == IDLE) begin
                    sync_err <= 1'b1;
                end else if (beat_cnt == LAST_BEAT) begin
                    crc10_en        <= 1'b1;
                    frame_tail_flag <= 1'b1;
                    crc10_data_out  <= tail_word;
                    frame_cnt       <= frame_cnt + 16'd1;
                    state           <= IDLE;
                    beat_cnt        <= 5'd0;
                    lane1           <= 10'h000;
                    lane2           <= 10'h000;
                    lane3           <= 10'h000;
                    lane4           <= 10'h000;
                    inject_pending  <= 1'b0;
                end else begin
                    lane1          <= full1;
                    lane2          <= full2;
                    lane3          <= full3;
                    lane4          <= full4;
                    beat_cnt       <= beat_cnt + 5'd1;
                    crc10_en       <= 1'b1;
                    crc10_data_out <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc10_frame_gen.sv
// tb/tb_crc10_frame_gen.sv - scoreboard bench for crc10_frame_gen
`timescale 1ns/1ps
module tb_crc10_frame_gen;

    logic        clk_390p625M = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [61:0] in_data;
    logic        err_inject;
    logic        crc10_en;
    logic [61:0] crc10_data_out;
    logic        frame_tail_flag;
    logic [15:0] frame_cnt;
    logic        sync_err;

    always #1.28 clk_390p625M = ~clk_390p625M;

    crc10_frame_gen dut (
        .clk_390p625M    (clk_390p625M),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_sof          (in_sof),
        .in_data         (in_data),
        .err_inject      (err_inject),
        .crc10_en        (crc10_en),
        .crc10_data_out  (crc10_data_out),
        .frame_tail_flag (frame_tail_flag),
        .frame_cnt       (frame_cnt),
        .sync_err        (sync_err)
    );

    typedef struct packed {
        logic [61:0] data;
        logic        tail;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          sync_seen = 0;
    int          sync_exp = 0;
    int          frames_exp = 0;
    logic [61:0] fr[26];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference CRC by polynomial long division of the augmented lane bitstream.
    function automatic logic [9:0] lane_crc(input int lane);
        logic [10:0] r;
        int hi, n;
        r = 11'h000;
        for (int b = 0; b < 26; b++) begin
            case (lane)
                1:       begin hi = 61; n = 15; end
                2:       begin hi = 46; n = (b < 25) ? 16 : 3; end
                3:       begin hi = 30; n = (b < 25) ? 15 : 0; end
                default: begin hi = 15; n = (b < 25) ? 16 : 0; end
            endcase
            for (int k = 0; k < n; k++) begin
                r = {r[9:0], fr[b][hi-k]};
                if (r[10]) r = r ^ 11'h633;
            end
        end
        for (int k = 0; k < 10; k++) begin
            r = {r[9:0], 1'b0};
            if (r[10]) r = r ^ 11'h633;
        end
        return r[9:0];
    endfunction

    function automatic logic [61:0] rand62();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[61:0];
    endfunction

    task automatic drive(input logic sof, input logic [61:0] d, input logic inj);
        @(negedge clk_390p625M);
        in_valid   = 1'b1;
        in_sof     = sof;
        in_data    = d;
        err_inject = inj;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk_390p625M);
            in_valid   = 1'b0;
            in_sof     = 1'b0;
            err_inject = 1'b0;
        end
    endtask

    task automatic send_partial(input int n);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back('{data: fr[b], tail: 1'b0});
            drive(b == 0, fr[b], 1'b0);
        end
    endtask

    task automatic send_frame(input logic inj, input int maxgap, input logic hand_en,
                              input logic [61:0] hand_tail);
        logic [61:0] t;
        if (hand_en) t = hand_tail;
        else t = {fr[25][61:44], lane_crc(1) ^ {9'h000, inj}, lane_crc(2), lane_crc(3),
                  lane_crc(4), 4'h0};
        for (int b = 0; b < 26; b++) begin
            if (b < 25) exp_q.push_back('{data: fr[b], tail: 1'b0});
            else exp_q.push_back('{data: t, tail: 1'b1});
            drive(b == 0, fr[b], (b == 0) ? inj : 1'b0);
            if (maxgap > 0) gap($urandom_range(0, maxgap));
        end
        frames_exp++;
        gap(2);
        check("frame_cnt", {48'h0, frame_cnt}, frames_exp);
    endtask

    always @(negedge clk_390p625M) begin
        if (rst_n && sync_err) sync_seen++;
        if (rst_n && crc10_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %h tail %b expected no output",
                         crc10_data_out, frame_tail_flag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat_data", {2'b0, crc10_data_out}, {2'b0, e.data});
                check("tail_flag", {63'h0, frame_tail_flag}, {63'h0, e.tail});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [61:0] saved[26];
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 62'h0; err_inject = 1'b0;
        repeat (3) @(negedge clk_390p625M);
        check("rst_en", {63'h0, crc10_en}, 64'h0);
        check("rst_tail", {63'h0, frame_tail_flag}, 64'h0);
        check("rst_data", {2'b0, crc10_data_out}, 64'h0);
        check("rst_cnt", {48'h0, frame_cnt}, 64'h0);
        check("rst_sync", {63'h0, sync_err}, 64'h0);
        rst_n = 1'b1;
        gap(2);

        for (int b = 0; b < 26; b++) fr[b] = 62'h0;
        send_frame(1'b0, 0, 1'b1, 62'h0);

        fr[25][47] = 1'b1;
        fr[25][44] = 1'b1;
        send_frame(1'b0, 0, 1'b1,
                   {15'h0001, 3'b001, 10'h233, 3'b100, 7'h33, 8'h0, 2'b0, 10'h0, 4'h0});

        for (int b = 0; b < 26; b++) fr[b] = rand62();
        saved = fr;
        send_frame(1'b0, 3, 1'b0, 62'h0);
        fr = saved;
        send_frame(1'b1, 2, 1'b0, 62'h0);
        for (int b = 0; b < 26; b++) fr[b] = rand62();
        send_frame(1'b0, 0, 1'b0, 62'h0);
        check("no_sync_err", sync_seen, 64'h0);

        for (int b = 0; b < 26; b++) fr[b] = rand62();
        send_partial(12);
        sync_exp++;
        for (int b = 0; b < 26; b++) fr[b] = rand62();
        send_frame(1'b0, 1, 1'b0, 62'h0);
        check("abort_sync", sync_seen, sync_exp);

        drive(1'b0, rand62(), 1'b0);
        sync_exp++;
        gap(3);
        check("stray_sync", sync_seen, sync_exp);

        for (int b = 0; b < 26; b++) fr[b] = rand62();
        fr[9][61] = 1'b1;
        send_partial(10);
        gap(1);
        @(posedge clk_390p625M);
        #0.3;
        rst_n = 1'b0;
        #0.3;
        check("async_rst_data", {2'b0, crc10_data_out}, 64'h0);
        check("async_rst_en", {63'h0, crc10_en}, 64'h0);
        check("async_rst_cnt", {48'h0, frame_cnt}, 64'h0);
        frames_exp = 0;
        @(negedge clk_390p625M);
        rst_n = 1'b1;
        gap(2);
        for (int b = 0; b < 26; b++) fr[b] = rand62();
        send_frame(1'b0, 2, 1'b0, 62'h0);

        gap(3);
        check("queue_empty", exp_q.size(), 64'h0);
        check("final_sync", sync_seen, sync_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
